// File: rtl/ahbl_test_port_if.sv
// -----------------------------------------------------------------------------
// ahbl_test_port_if
//
// AHB-Lite bus bundle for the ahbl_test_port responder. Signal names keep the
// ahbls_ prefix of the slave port they replace so waveforms and grep line up
// with the rest of the bus fabric.
//
//   ahbls_hready       bus-wide HREADY (driven by the interconnect)
//   ahbls_hready_resp  slave HREADYOUT
//   ahbls_hresp        slave response (always OKAY here)
//   ahbls_haddr        address
//   ahbls_hwrite       1 = write, 0 = read
//   ahbls_htrans       transfer type
//   ahbls_hsize/hburst/hprot/hmastlock  carried for completeness
//   ahbls_hwdata       write data
//   ahbls_hrdata       read data
//
// Modports: master (CPU / bench side), slave (responder side).
// -----------------------------------------------------------------------------
interface ahbl_test_port_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   logic              ahbls_hready;
   logic              ahbls_hready_resp;
   logic              ahbls_hresp;
   logic [W_ADDR-1:0] ahbls_haddr;
   logic              ahbls_hwrite;
   logic [1:0]        ahbls_htrans;
   logic [2:0]        ahbls_hsize;
   logic [2:0]        ahbls_hburst;
   logic [3:0]        ahbls_hprot;
   logic              ahbls_hmastlock;
   logic [W_DATA-1:0] ahbls_hwdata;
   logic [W_DATA-1:0] ahbls_hrdata;

   modport master (
      input  ahbls_hready,
      input  ahbls_hready_resp,
      input  ahbls_hresp,
      input  ahbls_hrdata,
      output ahbls_haddr,
      output ahbls_hwrite,
      output ahbls_htrans,
      output ahbls_hsize,
      output ahbls_hburst,
      output ahbls_hprot,
      output ahbls_hmastlock,
      output ahbls_hwdata
   );

   modport slave (
      input  ahbls_hready,
      input  ahbls_haddr,
      input  ahbls_hwrite,
      input  ahbls_htrans,
      input  ahbls_hsize,
      input  ahbls_hburst,
      input  ahbls_hprot,
      input  ahbls_hmastlock,
      input  ahbls_hwdata,
      output ahbls_hready_resp,
      output ahbls_hresp,
      output ahbls_hrdata
   );
endinterface

// File: rtl/ahbl_test_port.sv
// -----------------------------------------------------------------------------
// ahbl_test_port
//
// AHB-Lite responder giving code on the CPU a simulation-visible side channel:
//   0x0 PRINT   W: push hwdata[7:0] into the character FIFO
//               R: FIFO level (0..FIFO_DEPTH), zero-extended
//   0x4 EXIT    W: exit_vld <= 1 (sticky), exit_code <= hwdata.  R: exit_code
//   0x8 CYCLE   R: free-running cycle counter.  W: ignored
//   0xC SCRATCH R/W 32-bit word
// Only haddr[3:2] is decoded; higher and lower bits alias.
//
// A PRINT write whose data phase finds the FIFO full is held with
// hready_resp low until the drain logic frees a slot, which makes this the
// one wait-state-inserting slave on the bus.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   ahbls      AHB-Lite slave bundle (ahbl_test_port_if.slave)
//   char_vld   one-cycle strobe per character popped
//   char_data  character popped (held between strobes)
//   exit_vld   sticky, set by the first EXIT write
//   exit_code  last value written to EXIT
//
// Parameters: W_ADDR (>= 4), W_DATA (32), FIFO_DEPTH (power of two, >= 2),
// DRAIN_DIV (>= 1, cycles between successive character pops).
// -----------------------------------------------------------------------------
module ahbl_test_port #(
   parameter int W_ADDR     = 32,
   parameter int W_DATA     = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int DRAIN_DIV  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ahbl_test_port_if.slave      ahbls,
   output logic                 char_vld,
   output logic [7:0]           char_data,
   output logic                 exit_vld,
   output logic [W_DATA-1:0]    exit_code
);

   localparam int W_PTR   = $clog2(FIFO_DEPTH);
   localparam int W_LEVEL = W_PTR + 1;
   localparam int W_DRAIN = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

   localparam logic [W_LEVEL-1:0] FULL_LEVEL   = W_LEVEL'(FIFO_DEPTH);
   localparam logic [W_DRAIN-1:0] DRAIN_RELOAD = W_DRAIN'(DRAIN_DIV - 1);

   typedef enum logic [1:0] {
      REG_PRINT   = 2'd0,
      REG_EXIT    = 2'd1,
      REG_CYCLE   = 2'd2,
      REG_SCRATCH = 2'd3
   } reg_sel_e;

   // Data-phase context captured from the accepted address phase
   logic               dp_valid;
   logic               dp_write;
   reg_sel_e           dp_sel;

   // Character FIFO
   logic [7:0]         fifo_mem [FIFO_DEPTH];
   logic [W_PTR-1:0]   rd_ptr;
   logic [W_PTR-1:0]   wr_ptr;
   logic [W_LEVEL-1:0] level;
   logic [W_DRAIN-1:0] drain_cnt;

   logic [W_DATA-1:0]  cycle_cnt;
   logic [W_DATA-1:0]  scratch;

   logic               print_stall;
   logic               wr_commit;
   logic               push;
   logic               pop;

   // "Full" comes from the registered level, so a pop in the stalled cycle
   // only releases the push on the following edge.
   assign print_stall = dp_valid && dp_write && (dp_sel == REG_PRINT) &&
                        (level == FULL_LEVEL);
   assign wr_commit   = dp_valid && dp_write && !print_stall;
   assign push        = wr_commit && (dp_sel == REG_PRINT);
   assign pop         = (drain_cnt == '0) && (level != '0);

   assign ahbls.ahbls_hready_resp = !print_stall;
   assign ahbls.ahbls_hresp       = 1'b0;

   // -------------------------------------------------------------------------
   // Address phase capture. Bus-wide hready low (including our own stall)
   // keeps the current data phase alive.
   // -------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of process order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_sel   <= REG_PRINT;
      end else if (ahbls.ahbls_hready) begin
         dp_valid <= ahbls.ahbls_htrans[1];
         dp_write <= ahbls.ahbls_hwrite;
         dp_sel   <= reg_sel_e'(ahbls.ahbls_haddr[3:2]);
      end
   end

   // -------------------------------------------------------------------------
   // FIFO storage
   // -------------------------------------------------------------------------
   // NOTE: the storage array has no reset; an empty level counter already
   // makes stale entries unreachable, and leaving it out lets it map to RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= ahbls.ahbls_hwdata[7:0];
      end
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Drain: pop one character every DRAIN_DIV cycles while nonempty.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_cnt <= '0;
         char_vld  <= 1'b0;
         char_data <= 8'h00;
      end else if (pop) begin
         drain_cnt <= DRAIN_RELOAD;
         char_vld  <= 1'b1;
         char_data <= fifo_mem[rd_ptr];
      end else begin
         char_vld <= 1'b0;
         if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // EXIT, SCRATCH and CYCLE registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exit_vld  <= 1'b0;
         exit_code <= '0;
         scratch   <= '0;
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         if (wr_commit && (dp_sel == REG_EXIT)) begin
            exit_vld  <= 1'b1;
            exit_code <= ahbls.ahbls_hwdata;
         end
         if (wr_commit && (dp_sel == REG_SCRATCH)) begin
            scratch <= ahbls.ahbls_hwdata;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Read data: combinational from registered state, zero outside reads.
   // -------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      ahbls.ahbls_hrdata = '0;
      if (dp_valid && !dp_write) begin
         case (dp_sel)
            REG_PRINT:   ahbls.ahbls_hrdata = W_DATA'(level);
            REG_EXIT:    ahbls.ahbls_hrdata = exit_code;
            REG_CYCLE:   ahbls.ahbls_hrdata = cycle_cnt;
            REG_SCRATCH: ahbls.ahbls_hrdata = scratch;
            default:     ahbls.ahbls_hrdata = '0;
         endcase
      end
   end

   // Bus fields this responder deliberately ignores.
   wire unused_bus = ^{ahbls.ahbls_haddr[W_ADDR-1:4], ahbls.ahbls_haddr[1:0],
                       ahbls.ahbls_htrans[0], ahbls.ahbls_hsize,
                       ahbls.ahbls_hburst, ahbls.ahbls_hprot,
                       ahbls.ahbls_hmastlock};

endmodule
